// File: rtl/hazard_unit_if.sv
// Pipeline control types and the hazard/latch-control interface.
// Carries hazard inputs from the datapath and latch commands back to it.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2
    } pipe_state_t;
endpackage

interface hazard_if;
    import cpu_types_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        dREN_mem;
    logic        dWEN_mem;
    logic        dREN_ex;
    regbits_t    regWSEL_ex;
    regbits_t    rs_dec;
    regbits_t    rt_dec;
    logic        uses_rt_dec;
    logic        redirect_mem;
    logic        halt_mem;
    logic        halt_wb;
    pipe_state_t fd_state;
    pipe_state_t de_state;
    pipe_state_t em_state;
    pipe_state_t mw_state;
    logic        pc_en;
    logic        halted;
    word_t       stall_cycles;

    modport master (
        input  ihit, dhit, dREN_mem, dWEN_mem,
        input  dREN_ex, regWSEL_ex, rs_dec, rt_dec,
        input  uses_rt_dec, redirect_mem,
        input  halt_mem, halt_wb,
        output fd_state, de_state, em_state, mw_state,
        output pc_en, halted, stall_cycles
    );

    modport slave (
        output ihit, dhit, dREN_mem, dWEN_mem,
        output dREN_ex, regWSEL_ex, rs_dec, rt_dec,
        output uses_rt_dec, redirect_mem,
        output halt_mem, halt_wb,
        input  fd_state, de_state, em_state, mw_state,
        input  pc_en, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: per-cycle latch commands, PC enable, init/halt FSM.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    hazard_if.master h
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fsm_t;

    fsm_t state;
    fsm_t nxt;

    logic memWait;
    logic loadUse;
    logic [5:0] rule;

    assign memWait = (h.dREN_mem | h.dWEN_mem) & ~h.dhit;

    // $0 is hardwired, so a load targeting it never creates a dependency
    assign loadUse = h.dREN_ex
        && (h.regWSEL_ex != '0)
        && ((h.regWSEL_ex == h.rs_dec)
            || (h.uses_rt_dec
                && (h.regWSEL_ex == h.rt_dec)));

    // Priority-resolved to one-hot so the decoder below stays unique
    always_comb begin
        rule = '0;
        if (memWait)
            rule[0] = 1'b1;
        else if (h.halt_mem)
            rule[1] = 1'b1;
        else if (h.redirect_mem)
            rule[2] = 1'b1;
        else if (loadUse)
            rule[3] = 1'b1;
        else if (!h.ihit)
            rule[4] = 1'b1;
        else
            rule[5] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= INIT;
        else
            state <= nxt;
    end

    always_comb begin
        nxt        = state;
        h.fd_state = NORMAL;
        h.de_state = NORMAL;
        h.em_state = NORMAL;
        h.mw_state = NORMAL;
        h.pc_en    = 1'b0;
        h.halted   = 1'b0;
        unique case (state)
            INIT: begin
                h.fd_state = FLUSH;
                h.de_state = FLUSH;
                h.em_state = FLUSH;
                h.mw_state = FLUSH;
                nxt        = RUN;
            end
            RUN: begin
                unique case (1'b1)
                    rule[0]: begin
                        h.fd_state = STALL;
                        h.de_state = STALL;
                        h.em_state = STALL;
                        h.mw_state = FLUSH;
                    end
                    rule[1]: begin
                        h.fd_state = FLUSH;
                        h.de_state = FLUSH;
                        h.em_state = FLUSH;
                        nxt        = DRAIN;
                    end
                    rule[2]: begin
                        h.fd_state = FLUSH;
                        h.de_state = FLUSH;
                        h.em_state = FLUSH;
                        h.pc_en    = 1'b1;
                    end
                    rule[3]: begin
                        h.fd_state = STALL;
                        h.de_state = FLUSH;
                    end
                    rule[4]: begin
                        h.fd_state = FLUSH;
                    end
                    rule[5]: begin
                        h.pc_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            DRAIN: begin
                h.fd_state = FLUSH;
                h.de_state = FLUSH;
                h.em_state = FLUSH;
                if (h.halt_wb)
                    nxt = HALTED;
            end
            HALTED: begin
                h.fd_state = STALL;
                h.de_state = STALL;
                h.em_state = STALL;
                h.mw_state = STALL;
                h.halted   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_PERF_EN
    word_t cnt;
    logic  stallInc;

    // Halt entry is not a hazard stall, so rule 1 (index) is excluded
    assign stallInc = (state == RUN)
        && !h.pc_en && !rule[1];

    always_ff @(posedge CLK) begin
        if (!nRST)
            cnt <= '0;
        else if (stallInc && (cnt != 32'hFFFF_FFFF))
            cnt <= cnt + 32'd1;
    end

    assign h.stall_cycles = cnt;
`else
    assign h.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with a queue scoreboard.
// Driver pushes expected outputs; a negedge monitor pops and compares.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    hazard_if hif();

    hazard_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .h    (hif.master)
    );

    typedef struct {
        pipe_state_t fd;
        pipe_state_t de;
        pipe_state_t em;
        pipe_state_t mw;
        logic        pc;
        logic        hlt;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   nCmp;
    int   nBad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            logic [9:0] want;
            e    = expQ.pop_front();
            got  = {hif.fd_state, hif.de_state,
                    hif.em_state, hif.mw_state,
                    hif.pc_en, hif.halted};
            want = {e.fd, e.de, e.em, e.mw,
                    e.pc, e.hlt};
            nCmp++;
            if (got !== want) begin
                nBad++;
                $display("FAIL %s: got %b want %b",
                         e.name, got, want);
            end
        end
    end

    task automatic cyc(
        input logic        rst,
        input logic        ih,
        input logic        dh,
        input logic        drm,
        input logic        dwm,
        input logic        drx,
        input logic [4:0]  rw,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic        urt,
        input logic        rdr,
        input logic        hm,
        input logic        hwb,
        input pipe_state_t efd,
        input pipe_state_t ede,
        input pipe_state_t eem,
        input pipe_state_t emw,
        input logic        epc,
        input logic        ehl,
        input string       nm
    );
        exp_t e;
        @(posedge CLK);
        #1;
        nRST             = rst;
        hif.ihit         = ih;
        hif.dhit         = dh;
        hif.dREN_mem     = drm;
        hif.dWEN_mem     = dwm;
        hif.dREN_ex      = drx;
        hif.regWSEL_ex   = rw;
        hif.rs_dec       = rs;
        hif.rt_dec       = rt;
        hif.uses_rt_dec  = urt;
        hif.redirect_mem = rdr;
        hif.halt_mem     = hm;
        hif.halt_wb      = hwb;
        e.fd   = efd;
        e.de   = ede;
        e.em   = eem;
        e.mw   = emw;
        e.pc   = epc;
        e.hlt  = ehl;
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic chkCnt(input word_t want, input string nm);
        @(negedge CLK);
        nCmp++;
        if (hif.stall_cycles !== want) begin
            nBad++;
            $display("FAIL %s: got %0d want %0d",
                     nm, hif.stall_cycles, want);
        end
    endtask

    localparam pipe_state_t N = NORMAL;
    localparam pipe_state_t S = STALL;
    localparam pipe_state_t F = FLUSH;

    word_t expStall;

    initial begin
        nCmp = 0;
        nBad = 0;
`ifdef HAZARD_PERF_EN
        expStall = 32'd8;
`else
        expStall = 32'd0;
`endif
        nRST             = 1'b0;
        hif.ihit         = 1'b0;
        hif.dhit         = 1'b0;
        hif.dREN_mem     = 1'b0;
        hif.dWEN_mem     = 1'b0;
        hif.dREN_ex      = 1'b0;
        hif.regWSEL_ex   = '0;
        hif.rs_dec       = '0;
        hif.rt_dec       = '0;
        hif.uses_rt_dec  = 1'b0;
        hif.redirect_mem = 1'b0;
        hif.halt_mem     = 1'b0;
        hif.halt_wb      = 1'b0;
        // rst ih dh drm dwm drx rw rs rt urt rdr hm hwb
        cyc(0,1,1,0,0,0,0,0,0,0,0,0,0, F,F,F,F,0,0,"rstLow");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, F,F,F,F,0,0,"init");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, N,N,N,N,1,0,"run");
        cyc(1,1,1,0,0,1,5,5,0,0,0,0,0, S,F,N,N,0,0,"luRs");
        cyc(1,1,1,0,0,1,0,0,0,0,0,0,0, N,N,N,N,1,0,"luR0");
        cyc(1,1,1,0,0,1,7,3,7,1,0,0,0, S,F,N,N,0,0,"luRt");
        cyc(1,1,1,0,0,1,7,3,7,0,0,0,0, N,N,N,N,1,0,"rtUnused");
        cyc(1,1,1,0,0,0,5,5,5,1,0,0,0, N,N,N,N,1,0,"noLoad");
        cyc(1,1,0,1,0,1,5,5,0,0,0,0,0, S,S,S,F,0,0,"dWait1");
        cyc(1,1,0,1,0,1,5,5,0,0,0,0,0, S,S,S,F,0,0,"dWait2");
        cyc(1,1,0,1,0,1,5,5,0,0,0,0,0, S,S,S,F,0,0,"dWait3");
        cyc(1,1,1,1,0,1,5,5,0,0,0,0,0, S,F,N,N,0,0,"dHitLu");
        cyc(1,0,0,0,1,0,0,0,0,0,0,0,0, S,S,S,F,0,0,"wWait");
        cyc(1,0,1,0,0,0,0,0,0,0,0,0,0, F,N,N,N,0,0,"iMiss");
        cyc(1,0,1,0,0,0,0,0,0,0,1,0,0, F,F,F,N,1,0,"redir");
        cyc(1,1,1,0,0,1,5,5,0,0,1,0,0, F,F,F,N,1,0,"redirLu");
        cyc(1,1,1,0,0,0,0,0,0,0,1,1,0, F,F,F,N,0,0,"haltWins");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, F,F,F,N,0,0,"drain");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,1, F,F,F,N,0,0,"drainWb");
        cyc(1,1,1,0,0,0,0,0,0,0,1,0,0, S,S,S,S,0,1,"halted1");
        cyc(1,0,0,1,0,1,5,5,0,0,0,1,0, S,S,S,S,0,1,"halted2");
        chkCnt(expStall, "stallCnt");
        cyc(0,1,1,0,0,0,0,0,0,0,1,0,0, S,S,S,S,0,1,"haltRst");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, F,F,F,F,0,0,"reinit");
        chkCnt(32'd0, "cntClr");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, N,N,N,N,1,0,"rerun");
        cyc(1,1,0,1,0,0,0,0,0,0,0,0,0, S,S,S,F,0,0,"stallA");
        cyc(0,1,0,1,0,0,0,0,0,0,0,0,0, S,S,S,F,0,0,"stallRst");
        cyc(1,1,0,1,0,0,0,0,0,0,0,0,0, F,F,F,F,0,0,"stallInit");
        cyc(1,1,1,0,0,0,0,0,0,0,0,0,0, N,N,N,N,1,0,"rerun2");
        for (int i = 0; i < 20; i++) begin
            if (expQ.size() > 0)
                @(negedge CLK);
        end
        #1;
        if (expQ.size() > 0) begin
            nCmp++;
            nBad++;
            $display("FAIL drainQ: got %0d left want 0",
                     expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
